// File: rtl/csa_pkt_sched_if.sv
// Handshake/bus bundle between the ping-pong packet scheduler and the writer, cipher and reader.
// Latency: none (wires only).
// Backpressure: the writer is gated by wr_rdy, the reader is offered data by rd_vld, and the cipher is paced by bc_start/bcend.
// Ports: master = scheduler side; slave = writer/cipher/reader side.
interface csa_pkt_sched_if #(
    parameter int CNT_W = 16
);
    // writer side
    logic             wr_rdy;
    logic             wr_sel;
    logic             pkt_in_eop;
    logic [7:0]       pkt_pt;
    logic             pkt_odd;
    logic             pkt_enc;
    // control words
    logic [63:0]      cw_even;
    logic [63:0]      cw_odd;
    // cipher side
    logic             bc_start;
    logic [7:0]       bc_pt;
    logic             bc_buffh;
    logic             bc_oe;
    logic             bc_enc;
    logic [63:0]      bc_ck;
    logic             bcend;
    // reader side
    logic             rd_vld;
    logic             rd_sel;
    logic             rd_done;
    // statistics
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] tmo_cnt;

    modport master (
        output wr_rdy, wr_sel,
        input  pkt_in_eop, pkt_pt, pkt_odd, pkt_enc,
        input  cw_even, cw_odd,
        output bc_start, bc_pt, bc_buffh, bc_oe, bc_enc, bc_ck,
        input  bcend,
        output rd_vld, rd_sel,
        input  rd_done,
        output drop_cnt, tmo_cnt
    );

    modport slave (
        input  wr_rdy, wr_sel,
        output pkt_in_eop, pkt_pt, pkt_odd, pkt_enc,
        output cw_even, cw_odd,
        input  bc_start, bc_pt, bc_buffh, bc_oe, bc_enc, bc_ck,
        output bcend,
        input  rd_vld, rd_sel,
        output rd_done,
        input  drop_cnt, tmo_cnt
    );
endinterface

// File: rtl/csa_pkt_sched.sv
// Ping-pong scheduler for the two 188-byte packet halves shared by the TS writer, CSA cipher and reader.
// Latency: eop at n -> bc_start during n+1 (if cipher idle); bcend at m -> rd_vld at m+1; rd_done at k -> FREE at k+1.
// Backpressure: the writer is stalled via wr_rdy and eops with no free half are dropped and counted; the cipher is force-released after TIMEOUT_CYC.
// Ports: clk, nrst (async active-low), bus (csa_pkt_sched_if.master: writer, cw, cipher, reader, counters).
module csa_pkt_sched #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    csa_pkt_sched_if.master      bus
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {H_FREE, H_READY, H_CIPH, H_OUT} half_st_t;
    typedef enum logic {C_IDLE, C_WAIT} cph_st_t;

    half_st_t         hst_q [2];
    half_st_t         hst_d [2];
    logic [7:0]       pt_q  [2];
    logic             odd_q [2];
    logic             enc_q [2];

    logic             wr_sel_q, cph_sel_q, rd_sel_q;
    cph_st_t          cph_q, cph_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic [7:0]       bc_pt_q;
    logic             bc_buffh_q, bc_oe_q, bc_enc_q;
    logic [63:0]      bc_ck_q;
    logic [CNT_W-1:0] drop_q, tmo_q;

    logic             wr_free, eop_acc, eop_drop;
    logic             start, bc_hit, tmo_hit, release_h;
    logic             rd_acc;
    logic [63:0]      ck_sel;

    assign wr_free  = (hst_q[wr_sel_q] == H_FREE);
    assign eop_acc  = bus.pkt_in_eop & wr_free;
    assign eop_drop = bus.pkt_in_eop & ~wr_free;
    assign rd_acc   = bus.rd_done & (hst_q[rd_sel_q] == H_OUT);
    assign ck_sel   = odd_q[cph_sel_q] ? bus.cw_odd : bus.cw_even;

    // Cipher FSM. A bcend coinciding with the timeout wins, so only a
    // genuine miss bumps tmo_cnt.
    always_comb begin
        cph_d     = cph_q;
        timer_d   = timer_q;
        start     = 1'b0;
        bc_hit    = 1'b0;
        tmo_hit   = 1'b0;
        release_h = 1'b0;
        case (cph_q)
            C_IDLE: begin
                if (hst_q[cph_sel_q] == H_READY) begin
                    start   = 1'b1;
                    cph_d   = C_WAIT;
                    timer_d = TMR_W'(1);
                end
            end
            C_WAIT: begin
                if (bus.bcend) begin
                    bc_hit    = 1'b1;
                    release_h = 1'b1;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC)) begin
                    tmo_hit   = 1'b1;
                    release_h = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
                if (release_h) begin
                    cph_d   = C_IDLE;
                    timer_d = '0;
                end
            end
            default: cph_d = C_IDLE;
        endcase
    end

    // Each event needs a different source state, so at most one applies per half.
    always_comb begin
        hst_d[0] = hst_q[0];
        hst_d[1] = hst_q[1];
        if (eop_acc)   hst_d[wr_sel_q]  = H_READY;
        if (start)     hst_d[cph_sel_q] = H_CIPH;
        if (release_h) hst_d[cph_sel_q] = H_OUT;
        if (rd_acc)    hst_d[rd_sel_q]  = H_FREE;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hst_q[0]   <= H_FREE;
            hst_q[1]   <= H_FREE;
            pt_q[0]    <= '0;
            pt_q[1]    <= '0;
            odd_q[0]   <= 1'b0;
            odd_q[1]   <= 1'b0;
            enc_q[0]   <= 1'b0;
            enc_q[1]   <= 1'b0;
            wr_sel_q   <= 1'b0;
            cph_sel_q  <= 1'b0;
            rd_sel_q   <= 1'b0;
            cph_q      <= C_IDLE;
            timer_q    <= '0;
            bc_pt_q    <= 8'hBC;
            bc_buffh_q <= 1'b0;
            bc_oe_q    <= 1'b0;
            bc_enc_q   <= 1'b0;
            bc_ck_q    <= '0;
            drop_q     <= '0;
            tmo_q      <= '0;
        end else begin
            hst_q[0] <= hst_d[0];
            hst_q[1] <= hst_d[1];
            cph_q    <= cph_d;
            timer_q  <= timer_d;
            if (eop_acc) begin
                pt_q[wr_sel_q]  <= bus.pkt_pt;
                odd_q[wr_sel_q] <= bus.pkt_odd;
                enc_q[wr_sel_q] <= bus.pkt_enc;
                wr_sel_q        <= ~wr_sel_q;
            end
            // Latch the launch parameters so the cipher sees them stable
            // for the whole packet, even if the control words change.
            if (start) begin
                bc_pt_q    <= pt_q[cph_sel_q];
                bc_buffh_q <= cph_sel_q;
                bc_oe_q    <= odd_q[cph_sel_q];
                bc_enc_q   <= enc_q[cph_sel_q];
                bc_ck_q    <= ck_sel;
            end
            if (release_h) cph_sel_q <= ~cph_sel_q;
            if (rd_acc)    rd_sel_q  <= ~rd_sel_q;
            if (eop_drop && drop_q != {CNT_W{1'b1}}) drop_q <= drop_q + CNT_W'(1);
            if (tmo_hit  && tmo_q  != {CNT_W{1'b1}}) tmo_q  <= tmo_q  + CNT_W'(1);
        end
    end

    // Launch fields are driven straight from the half during the start cycle
    // so the cipher sees them with its start pulse, then held.
    assign bus.wr_rdy   = wr_free;
    assign bus.wr_sel   = wr_sel_q;
    assign bus.bc_start = start;
    assign bus.bc_pt    = start ? pt_q[cph_sel_q]  : bc_pt_q;
    assign bus.bc_buffh = start ? cph_sel_q        : bc_buffh_q;
    assign bus.bc_oe    = start ? odd_q[cph_sel_q] : bc_oe_q;
    assign bus.bc_enc   = start ? enc_q[cph_sel_q] : bc_enc_q;
    assign bus.bc_ck    = start ? ck_sel           : bc_ck_q;
    assign bus.rd_vld   = (hst_q[rd_sel_q] == H_OUT);
    assign bus.rd_sel   = rd_sel_q;
    assign bus.drop_cnt = drop_q;
    assign bus.tmo_cnt  = tmo_q;

    // bc_hit only documents the bcend-wins priority; keep it observable.
    logic unused_ok;
    assign unused_ok = bc_hit;

endmodule

// File: tb/tb_csa_pkt_sched.sv
// Directed bench for the ping-pong packet scheduler.
// Inputs are driven and outputs sampled on the falling edge; the DUT registers on the rising edge.
// Every check is an immediate assertion against a hand-computed value.
module tb_csa_pkt_sched;

    localparam logic [63:0] CW_O  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] CW_E  = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] CW_O2 = 64'h5555_AAAA_5555_AAAA;

    logic clk;
    logic nrst;
    int   n_chk;
    int   n_fail;

    csa_pkt_sched_if #(.CNT_W(16)) bus ();

    csa_pkt_sched #(.TIMEOUT_CYC(1024), .CNT_W(16)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_eop(input logic [7:0] pt, input logic odd, input logic enc);
        bus.pkt_in_eop = 1'b1;
        bus.pkt_pt     = pt;
        bus.pkt_odd    = odd;
        bus.pkt_enc    = enc;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " wr_rdy"},   64'(bus.wr_rdy),   64'd1);
        chk({tag, " wr_sel"},   64'(bus.wr_sel),   64'd0);
        chk({tag, " bc_start"}, 64'(bus.bc_start), 64'd0);
        chk({tag, " bc_pt"},    64'(bus.bc_pt),    64'hBC);
        chk({tag, " bc_buffh"}, 64'(bus.bc_buffh), 64'd0);
        chk({tag, " bc_oe"},    64'(bus.bc_oe),    64'd0);
        chk({tag, " bc_enc"},   64'(bus.bc_enc),   64'd0);
        chk({tag, " bc_ck"},    bus.bc_ck,         64'd0);
        chk({tag, " rd_vld"},   64'(bus.rd_vld),   64'd0);
        chk({tag, " rd_sel"},   64'(bus.rd_sel),   64'd0);
        chk({tag, " drop_cnt"}, 64'(bus.drop_cnt), 64'd0);
        chk({tag, " tmo_cnt"},  64'(bus.tmo_cnt),  64'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        nrst            = 1'b0;
        bus.pkt_in_eop  = 1'b0;
        bus.pkt_pt      = 8'h00;
        bus.pkt_odd     = 1'b0;
        bus.pkt_enc     = 1'b0;
        bus.cw_even     = CW_E;
        bus.cw_odd      = CW_O;
        bus.bcend       = 1'b0;
        bus.rd_done     = 1'b0;

        // ---- reset state
        step();
        chk_reset_vals("reset");
        nrst = 1'b1;
        step();
        step();

        // ---- 1: launch on half 0, odd key
        set_eop(8'd4, 1'b1, 1'b1);
        step();
        bus.pkt_in_eop = 1'b0;
        chk("t1 bc_start", 64'(bus.bc_start), 64'd1);
        chk("t1 bc_buffh", 64'(bus.bc_buffh), 64'd0);
        chk("t1 bc_pt",    64'(bus.bc_pt),    64'd4);
        chk("t1 bc_ck",    bus.bc_ck,         CW_O);
        chk("t1 bc_oe",    64'(bus.bc_oe),    64'd1);
        chk("t1 bc_enc",   64'(bus.bc_enc),   64'd1);
        chk("t1 wr_sel",   64'(bus.wr_sel),   64'd1);
        chk("t1 wr_rdy",   64'(bus.wr_rdy),   64'd1);
        step();
        chk("t1 start pulse", 64'(bus.bc_start), 64'd0);
        chk("t1 pt held",     64'(bus.bc_pt),    64'd4);
        bus.cw_odd = CW_O2;
        step();
        chk("t1 ck held after cw change", bus.bc_ck, CW_O);

        // ---- 2: bcend 300 cycles after the start cycle
        repeat (297) step();
        chk("t2 rd_vld before bcend", 64'(bus.rd_vld), 64'd0);
        bus.bcend = 1'b1;
        step();
        bus.bcend = 1'b0;
        chk("t2 rd_vld", 64'(bus.rd_vld), 64'd1);
        chk("t2 rd_sel", 64'(bus.rd_sel), 64'd0);
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
        chk("t2 rd_vld after done", 64'(bus.rd_vld), 64'd0);
        chk("t2 rd_sel after done", 64'(bus.rd_sel), 64'd1);
        chk("t2 wr_rdy",            64'(bus.wr_rdy), 64'd1);
        bus.cw_odd = CW_O;

        // ---- 3: fill both halves with no reader, third eop dropped
        set_eop(8'd10, 1'b0, 1'b0);
        step();
        bus.pkt_in_eop = 1'b0;
        chk("t3 start a", 64'(bus.bc_start), 64'd1);
        chk("t3 buffh a", 64'(bus.bc_buffh), 64'd1);
        chk("t3 ck even", bus.bc_ck,         CW_E);
        step();
        bus.bcend = 1'b1;
        step();
        bus.bcend = 1'b0;
        chk("t3 rd_vld a", 64'(bus.rd_vld), 64'd1);
        chk("t3 rd_sel a", 64'(bus.rd_sel), 64'd1);
        set_eop(8'd11, 1'b1, 1'b1);
        step();
        bus.pkt_in_eop = 1'b0;
        chk("t3 start b", 64'(bus.bc_start), 64'd1);
        chk("t3 buffh b", 64'(bus.bc_buffh), 64'd0);
        chk("t3 pt b",    64'(bus.bc_pt),    64'd11);
        step();
        bus.bcend = 1'b1;
        step();
        bus.bcend = 1'b0;
        chk("t3 wr_rdy full", 64'(bus.wr_rdy), 64'd0);
        set_eop(8'd12, 1'b0, 1'b0);
        step();
        bus.pkt_in_eop = 1'b0;
        chk("t3 drop_cnt",     64'(bus.drop_cnt), 64'd1);
        chk("t3 no start",     64'(bus.bc_start), 64'd0);
        chk("t3 wr_sel kept",  64'(bus.wr_sel),   64'd1);
        chk("t3 wr_rdy still", 64'(bus.wr_rdy),   64'd0);

        // ---- 5: rd_done on half 0 together with bcend on half 1
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
        chk("t5 rd_sel 0", 64'(bus.rd_sel), 64'd0);
        chk("t5 rd_vld 0", 64'(bus.rd_vld), 64'd1);
        chk("t5 wr_rdy",   64'(bus.wr_rdy), 64'd1);
        set_eop(8'h20, 1'b1, 1'b1);
        step();
        bus.pkt_in_eop = 1'b0;
        chk("t5 start h1", 64'(bus.bc_buffh), 64'd1);
        step();
        bus.rd_done = 1'b1;
        bus.bcend   = 1'b1;
        step();
        bus.rd_done = 1'b0;
        bus.bcend   = 1'b0;
        chk("t5 rd_sel 1",  64'(bus.rd_sel),  64'd1);
        chk("t5 rd_vld 1",  64'(bus.rd_vld),  64'd1);
        chk("t5 wr_sel 0",  64'(bus.wr_sel),  64'd0);
        chk("t5 h0 free",   64'(bus.wr_rdy),  64'd1);
        chk("t5 tmo_cnt",   64'(bus.tmo_cnt), 64'd0);

        // ---- 4: cipher timeout with a second packet queued behind it
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
        chk("t4 rd_vld idle", 64'(bus.rd_vld), 64'd0);
        set_eop(8'd7, 1'b0, 1'b1);
        step();
        bus.pkt_in_eop = 1'b0;
        chk("t4 start h0", 64'(bus.bc_start), 64'd1);
        chk("t4 buffh h0", 64'(bus.bc_buffh), 64'd0);
        set_eop(8'd9, 1'b1, 1'b0);
        step();
        bus.pkt_in_eop = 1'b0;
        repeat (1023) step();
        chk("t4 rd_vld at limit", 64'(bus.rd_vld),  64'd0);
        chk("t4 tmo at limit",    64'(bus.tmo_cnt), 64'd0);
        step();
        chk("t4 rd_vld",     64'(bus.rd_vld),   64'd1);
        chk("t4 rd_sel",     64'(bus.rd_sel),   64'd0);
        chk("t4 tmo_cnt",    64'(bus.tmo_cnt),  64'd1);
        chk("t4 next start", 64'(bus.bc_start), 64'd1);
        chk("t4 next buffh", 64'(bus.bc_buffh), 64'd1);
        chk("t4 next pt",    64'(bus.bc_pt),    64'd9);
        chk("t4 next ck",    bus.bc_ck,         CW_O);

        // ---- 6: reset while the cipher is waiting
        repeat (3) step();
        nrst = 1'b0;
        #1;
        chk_reset_vals("t6 in reset");
        step();
        nrst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t6 no start", 64'(bus.bc_start), 64'd0);
        end
        chk("t6 rd_vld", 64'(bus.rd_vld), 64'd0);
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
        chk("t6 rd_done ignored", 64'(bus.rd_sel), 64'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_fail);
        $finish;
    end

endmodule
